// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end.
// Owns the PC and the req/ack handshake to instruction memory, and holds one
// fetched instruction in an output slot for decode.
//
// Handshake summary: imem_req asserts in S_FETCH when the output slot is free
// or freeing (!instr_valid || !stall) and then stays high with a stable
// imem_addr until imem_ack. In S_DROP it stays high on the abandoned address
// until that fetch completes. imem_ack is only taken while imem_req=1. The
// slot is consumed on any cycle with instr_valid && !stall.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : misaligned redirect targets are forced to a word boundary and
//               align_err pulses for one cycle after the redirect.
//   undefined : redirect_pc is loaded unchanged and align_err is tied low.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] seq_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        align_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pending_q, pending_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;

  logic        slot_free;
  logic        req_fetch;
  logic        ack_fetch;
  logic        abandon;
  logic [31:0] redirect_target;

  // Request and acceptance qualifiers shared by the FSM and the datapath
  always_comb begin
    slot_free = !instr_valid_q || !stall;
    req_fetch = (state_q == S_FETCH) && (pending_q || slot_free);
    ack_fetch = req_fetch && imem_ack;
    // A redirect while a fetch is outstanding and not completing this cycle
    // leaves that fetch in flight; its data must be thrown away later.
    abandon   = redirect_valid && req_fetch && !imem_ack;
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_err_q, align_err_d;

  // Word-align redirect targets and flag the ones that needed it
  always_comb begin
    redirect_target = {redirect_pc[31:2], 2'b00};
    align_err_d     = redirect_valid && (redirect_pc[1:0] != 2'b00);
  end

  // One-cycle misalignment pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_err_q <= 1'b0;
    end else begin
      align_err_q <= align_err_d;
    end
  end

  assign align_err = align_err_q;
`else
  // Redirect targets are taken as given; no alignment reporting
  always_comb begin
    redirect_target = redirect_pc;
  end

  assign align_err = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: one idle bubble, then fetch; park in DROP on abandon
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (abandon) state_d = S_DROP;
      S_DROP:  if (imem_ack) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: memory request and address
  always_comb begin
    imem_req  = req_fetch || (state_q == S_DROP);
    imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;
  end

  // Datapath next-state: PC, pending bit, drop address and output slot
  always_comb begin
    pc_d          = pc_q;
    drop_addr_d   = drop_addr_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    // A request stays outstanding until acked; a redirect hands it to S_DROP.
    pending_d     = req_fetch && !imem_ack && !redirect_valid;

    if (redirect_valid) begin
      // Redirect wins over everything, including stall and a same-cycle ack.
      pc_d          = redirect_target;
      instr_valid_d = 1'b0;
      if (abandon) begin
        drop_addr_d = pc_q;
      end
    end else if (ack_fetch) begin
      instr_d       = imem_rdata;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b1;
      pc_d          = seq_pc;
    end else if (instr_valid_q && !stall) begin
      instr_valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      pending_q     <= 1'b0;
      drop_addr_q   <= RESET_PC;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      pending_q     <= pending_d;
      drop_addr_q   <= drop_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench for pc_fetch_unit.
// The bench models the external pc+4 adder and an instruction memory whose
// word at address A is ~A. The memory only acks as many fetches as the test
// has granted, with a programmable wait, so every scenario is cycle-exact.
// Consumed instructions are checked in order against an expected queue.
module tb_pc_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] pc;
  logic [31:0] seq_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        align_err;

  // External adder: in1 = pc, in2 = 4
  assign seq_pc = pc + 32'd4;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .seq_pc         (seq_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .align_err      (align_err)
  );

  // ---------------- counters / scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [63:0] exp_q[$];

  int acks_granted = 0;
  int acks_done    = 0;
  int ack_delay    = 0;
  bit spurious_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic exp_push(input logic [31:0] a, input logic [31:0] w);
    exp_q.push_back({a, w});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait until every granted ack has been applied; ends 1 unit after that edge
  task automatic wait_mem(input int budget);
    int n;
    n = 0;
    while (acks_done != acks_granted && n < budget) begin
      step();
      n++;
    end
    if (acks_done != acks_granted) begin
      n_total++;
      $display("FAIL wait_mem timeout: acks done %0d granted %0d", acks_done, acks_granted);
      acks_done = acks_granted;
    end
  endtask

  // ---------------- memory model ----------------
  initial begin
    int wait_cnt;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    wait_cnt   = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        imem_ack = spurious_ack;
        wait_cnt = 0;
      end else if (imem_req && acks_done != acks_granted) begin
        if (wait_cnt == ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = ~imem_addr;
          wait_cnt   = 0;
          acks_done  = acks_done + 1;
        end else begin
          imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_ack   = spurious_ack;
        imem_rdata = 32'hDEAD_BEEF;
        wait_cnt   = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && instr_valid && !stall) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL consume: unexpected instr_pc %h instr %h", instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        check("consume instr_pc", instr_pc, e[63:32]);
        check("consume instr", instr, e[31:0]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst pc", pc, 32'h0);
    check("rst imem_req", {31'b0, imem_req}, 32'h0);
    check("rst imem_addr", imem_addr, 32'h0);
    check("rst instr_valid", {31'b0, instr_valid}, 32'h0);
    check("rst instr", instr, 32'h0);
    check("rst instr_pc", instr_pc, 32'h0);
    check("rst align_err", {31'b0, align_err}, 32'h0);

    // 1: one idle bubble, then zero-wait fetch at 1 instr/cycle
    rst = 1'b0;
    check("t1 idle no req", {31'b0, imem_req}, 32'h0);
    ack_delay = 0;
    acks_granted += 4;
    exp_push(32'h0000_0000, 32'hFFFF_FFFF);
    exp_push(32'h0000_0004, 32'hFFFF_FFFB);
    exp_push(32'h0000_0008, 32'hFFFF_FFF7);
    exp_push(32'h0000_000C, 32'hFFFF_FFF3);
    step();
    check("t1 first req", {31'b0, imem_req}, 32'h1);
    check("t1 first addr", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1 valid", {31'b0, instr_valid}, 32'h1);
      check("t1 instr_pc", instr_pc, 32'(i * 4));
    end
    step();
    step();

    // 2: stall holds the slot; no new request; stray acks ignored
    stall = 1'b1;
    acks_granted += 1;
    exp_push(32'h0000_0010, 32'hFFFF_FFEF);
    step();
    check("t2 valid", {31'b0, instr_valid}, 32'h1);
    check("t2 instr_pc", instr_pc, 32'h10);
    spurious_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t2 no req", {31'b0, imem_req}, 32'h0);
      check("t2 held pc", instr_pc, 32'h10);
      check("t2 held instr", instr, 32'hFFFF_FFEF);
      step();
    end
    spurious_ack = 1'b0;
    check("t2 pc after stall", pc, 32'h14);
    check("t2 still valid", {31'b0, instr_valid}, 32'h1);
    stall = 1'b0;
    acks_granted += 2;
    exp_push(32'h0000_0014, 32'hFFFF_FFEB);
    exp_push(32'h0000_0018, 32'hFFFF_FFE7);
    wait_mem(20);
    step();
    step();
    check("t2 queue empty", 32'(exp_q.size()), 32'h0);

    // 3a: redirect to 0x10 while 0x1C is outstanding -> drop 0x1C
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    step();
    redirect_valid = 1'b0;
    check("t3 drop addr", imem_addr, 32'h1C);
    check("t3 drop req", {31'b0, imem_req}, 32'h1);
    acks_granted += 1;
    wait_mem(20);
    check("t3 req addr 10", imem_addr, 32'h10);
    check("t3 req 10", {31'b0, imem_req}, 32'h1);

    // 3b: slow ack of 0x10 with a redirect to 0x200 in the meantime
    ack_delay = 4;
    acks_granted += 2;
    exp_push(32'h0000_0200, 32'hFFFF_FDFF);
    step();
    check("t3 addr c1", imem_addr, 32'h10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3 addr stable", imem_addr, 32'h10);
      check("t3 req stable", {31'b0, imem_req}, 32'h1);
      step();
    end
    check("t3 new addr", imem_addr, 32'h200);
    check("t3 pc", pc, 32'h200);
    wait_mem(30);
    check("t3 instr_pc", instr_pc, 32'h200);
    ack_delay = 0;

    // 4: redirect on the same cycle as the ack of 0x8
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4;
    acks_granted += 2;
    exp_push(32'h0000_0004, 32'hFFFF_FFFB);
    step();
    redirect_valid = 1'b0;
    check("t4 flushed", {31'b0, instr_valid}, 32'h0);
    step();
    check("t4 instr_pc 4", instr_pc, 32'h4);
    step();
    check("t4 addr 8", imem_addr, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    acks_granted += 1;
    step();
    redirect_valid = 1'b0;
    check("t4 valid after redirect", {31'b0, instr_valid}, 32'h0);
    check("t4 addr 40", imem_addr, 32'h40);
    acks_granted += 1;
    exp_push(32'h0000_0040, 32'hFFFF_FFBF);
    wait_mem(20);
    check("t4 instr_pc 40", instr_pc, 32'h40);

    // 5: PC wraps modulo 2^32
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    acks_granted += 1;
    step();
    redirect_valid = 1'b0;
    acks_granted += 1;
    exp_push(32'hFFFF_FFFC, 32'h0000_0003);
    wait_mem(20);
    check("t5 instr_pc", instr_pc, 32'hFFFF_FFFC);
    check("t5 pc wrap", pc, 32'h0);
    check("t5 next addr", imem_addr, 32'h0);
    check("t5 next req", {31'b0, imem_req}, 32'h1);

    // 6: misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    acks_granted += 1;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    check("t6 pc", pc, 32'h100);
    check("t6 align_err", {31'b0, align_err}, 32'h1);
`else
    check("t6 pc", pc, 32'h103);
    check("t6 align_err", {31'b0, align_err}, 32'h0);
`endif
    step();
    check("t6 align_err pulse end", {31'b0, align_err}, 32'h0);
    acks_granted += 1;
`ifdef FETCH_ALIGN_CHECK_EN
    exp_push(32'h0000_0100, 32'hFFFF_FEFF);
`else
    exp_push(32'h0000_0103, 32'hFFFF_FEFC);
`endif
    wait_mem(20);
`ifdef FETCH_ALIGN_CHECK_EN
    check("t6 instr_pc", instr_pc, 32'h100);
`else
    check("t6 instr_pc", instr_pc, 32'h103);
`endif
    step();
    step();
    check("t6 queue empty", 32'(exp_q.size()), 32'h0);

    // 7: reset with a request outstanding; acks during/after reset ignored
    rst          = 1'b1;
    spurious_ack = 1'b1;
    #1;
    check("t7 async req", {31'b0, imem_req}, 32'h0);
    check("t7 async valid", {31'b0, instr_valid}, 32'h0);
    check("t7 async pc", pc, 32'h0);
    step();
    step();
    rst = 1'b0;
    step();
    spurious_ack = 1'b0;
    check("t7 valid after idle", {31'b0, instr_valid}, 32'h0);
    check("t7 pc after idle", pc, 32'h0);
    check("t7 req after idle", {31'b0, imem_req}, 32'h1);
    step();
    check("t7 final queue empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
